// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard and stall controller for a five-stage pipeline. Decides, every
// cycle, which pipeline registers advance, which get bubbled and which
// get squashed, based on memory stalls, taken branches and load-use
// dependencies. A small FSM tracks outstanding memory waits and a
// retired HALT; saturating counters record stall and flush activity.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [2:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_to_reg,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_done,
  input  logic        halt_in,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_nop,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        mem_timeout
);

  // FSM encodings; 2'd3 is unreachable and recovers to RUN.
  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MEMWAIT = 2'd1;
  localparam logic [1:0] ST_HALTED  = 2'd2;

  // Timeout threshold widened by one bit so it compares cleanly against
  // the incremented 8-bit wait count.
  localparam logic [8:0] LP_TIMEOUT = 9'(TIMEOUT);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Registered state
  logic [1:0]  r_state;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;
  logic [7:0]  r_wait_cnt;
  logic        r_mem_timeout;

  // Combinational decode
  logic        w_live;
  logic        w_rs_hit;
  logic        w_rt_hit;
  logic        w_luh;
  logic        w_mstall;
  logic        w_flush_cyc;
  logic        w_stall_cyc;
  logic [1:0]  w_state_nxt;
  logic        w_enter_wait;
  logic [8:0]  w_wait_inc;

  logic        w_pc_en;
  logic        w_ifid_en;
  logic        w_ifid_flush;
  logic        w_idex_en;
  logic        w_idex_nop;
  logic        w_exmem_en;
  logic        w_memwb_en;

  // Anything other than HALTED behaves as a live pipeline.
  assign w_live   = (r_state != ST_HALTED);

  // A load in EX whose destination an ID source operand needs.
  assign w_rs_hit = id_uses_rs & (id_rs == ex_rd);
  assign w_rt_hit = id_uses_rt & (id_rt == ex_rd);
  assign w_luh    = ex_mem_to_reg & ex_reg_write & (w_rs_hit | w_rt_hit);

  // Data memory has not answered; the whole pipe must freeze.
  assign w_mstall = w_live & mem_req & ~mem_done;

  // Pick pipeline-register controls by priority:
  // halted > memory stall > taken branch > load-use > normal flow.
  always_comb begin
    w_pc_en      = 1'b1;
    w_ifid_en    = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_en    = 1'b1;
    w_idex_nop   = 1'b0;
    w_exmem_en   = 1'b1;
    w_memwb_en   = 1'b1;
    if (!w_live) begin
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_idex_en    = 1'b0;
      w_exmem_en   = 1'b0;
      w_memwb_en   = 1'b0;
    end else if (w_mstall) begin
      // EX is held, so a taken branch here simply waits its turn.
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_idex_en    = 1'b0;
      w_exmem_en   = 1'b0;
      w_memwb_en   = 1'b0;
    end else if (ex_branch_taken) begin
      // Redirect: squash the two younger instructions. Any load-use
      // dependency belongs to a squashed instruction and is moot.
      w_ifid_flush = 1'b1;
      w_idex_nop   = 1'b1;
    end else if (w_luh) begin
      // Hold PC and IF/ID one cycle, feed a bubble into EX.
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_idex_nop   = 1'b1;
    end else begin
      w_pc_en      = 1'b1;
    end
  end

  assign pc_en      = w_pc_en;
  assign ifid_en    = w_ifid_en;
  assign ifid_flush = w_ifid_flush;
  assign idex_en    = w_idex_en;
  assign idex_nop   = w_idex_nop;
  assign exmem_en   = w_exmem_en;
  assign memwb_en   = w_memwb_en;

  // Next-state decode; a retiring HALT overrides every other condition.
  always_comb begin
    w_state_nxt = ST_RUN;
    if (halt_in) begin
      w_state_nxt = ST_HALTED;
    end else begin
      case (r_state)
        ST_RUN:     w_state_nxt = w_mstall ? ST_MEMWAIT : ST_RUN;
        ST_MEMWAIT: w_state_nxt = (mem_done | ~mem_req) ? ST_RUN : ST_MEMWAIT;
        ST_HALTED:  w_state_nxt = ST_HALTED;
        default:    w_state_nxt = ST_RUN;
      endcase
    end
  end

  assign w_enter_wait = (r_state != ST_MEMWAIT) & (w_state_nxt == ST_MEMWAIT);
  assign w_wait_inc   = {1'b0, r_wait_cnt} + 9'd1;

  // Cycles that count as stalls or flushes; HALTED never counts.
  assign w_stall_cyc  = w_live & ~w_pc_en;
  assign w_flush_cyc  = w_live & ~w_mstall & ex_branch_taken;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Memory-wait length: restarts on entering MEMWAIT, counts each
  // MEMWAIT cycle and parks at its maximum instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= 8'd0;
    end else if (w_enter_wait) begin
      r_wait_cnt <= 8'd0;
    end else if ((r_state == ST_MEMWAIT) && (r_wait_cnt != 8'hFF)) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end else begin
      r_wait_cnt <= r_wait_cnt;
    end
  end

  // Sticky timeout flag once a single wait reaches the threshold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_timeout <= 1'b0;
    end else if ((r_state == ST_MEMWAIT) && (w_wait_inc >= LP_TIMEOUT)) begin
      r_mem_timeout <= 1'b1;
    end else begin
      r_mem_timeout <= r_mem_timeout;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
    end else if (w_stall_cyc && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  // Saturating branch-flush counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush_cnt <= 16'd0;
    end else if (w_flush_cyc && (r_flush_cnt != CNT_MAX)) begin
      r_flush_cnt <= r_flush_cnt + 16'd1;
    end else begin
      r_flush_cnt <= r_flush_cnt;
    end
  end

  assign state       = r_state;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;
  assign mem_timeout = r_mem_timeout;

endmodule
